// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter for a single asynchronous SRAM port.
// Each access is sequenced IDLE -> SETUP -> [WAIT...] -> DONE with registered bus outputs.
module sram_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_read,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_read,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic [1:0]            gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dout,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_rw,
    output logic                  mem_cs_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            gnt_d;
    logic                  m0_ack_d, m1_ack_d;
    logic [DATA_WIDTH-1:0] m0_rdata_d, m1_rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_dout_d;
    logic                  mem_rw_d, mem_cs_n_d;
    logic                  pick1;
    logic                  finish;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata;
        m1_rdata_d = m1_rdata;
        mem_addr_d = mem_addr;
        mem_dout_d = mem_dout;
        mem_rw_d   = mem_rw;
        mem_cs_n_d = mem_cs_n;
        finish     = 1'b0;
        // On a tie, master 1 wins only if master 0 was served last.
        pick1      = m1_req && (!m0_req || !last_q);

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    last_d     = pick1;
                    gnt_d      = pick1 ? 2'b10 : 2'b01;
                    mem_addr_d = pick1 ? m1_addr  : m0_addr;
                    mem_dout_d = pick1 ? m1_wdata : m0_wdata;
                    mem_rw_d   = pick1 ? m1_read  : m0_read;
                    mem_cs_n_d = 1'b0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (WAIT_STATES == 0) begin
                    finish = 1'b1;
                end else begin
                    cnt_d   = WS_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion edge: mem_rw still holds the latched read flag and gnt the owner.
        if (finish) begin
            state_d = S_DONE;
            if (mem_rw) begin
                if (gnt[0]) m0_rdata_d = mem_din;
                if (gnt[1]) m1_rdata_d = mem_din;
            end
            m0_ack_d   = gnt[0];
            m1_ack_d   = gnt[1];
            mem_cs_n_d = 1'b1;
            mem_rw_d   = 1'b1;
            gnt_d      = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            gnt      <= 2'b00;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            mem_addr <= '0;
            mem_dout <= '0;
            mem_rw   <= 1'b1;
            mem_cs_n <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt      <= gnt_d;
            m0_ack   <= m0_ack_d;
            m1_ack   <= m1_ack_d;
            m0_rdata <= m0_rdata_d;
            m1_rdata <= m1_rdata_d;
            mem_addr <= mem_addr_d;
            mem_dout <= mem_dout_d;
            mem_rw   <= mem_rw_d;
            mem_cs_n <= mem_cs_n_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: one instance with WAIT_STATES=0 (index 0) and one with WAIT_STATES=3
// (index 1), each on its own SRAM model, checked against a transaction-level reference.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       m0_req, m1_req, m0_read, m1_read;
    logic [1:0][15:0] m0_addr, m1_addr, mem_addr;
    logic [1:0][7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_dout, mem_din;
    logic [1:0]       m0_ack, m1_ack, mem_rw, mem_cs_n;
    logic [1:0][1:0]  gnt;

    sram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req[0]), .m0_read(m0_read[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
        .m0_rdata(m0_rdata[0]), .m0_ack(m0_ack[0]),
        .m1_req(m1_req[0]), .m1_read(m1_read[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
        .m1_rdata(m1_rdata[0]), .m1_ack(m1_ack[0]),
        .gnt(gnt[0]), .mem_addr(mem_addr[0]), .mem_dout(mem_dout[0]), .mem_din(mem_din[0]),
        .mem_rw(mem_rw[0]), .mem_cs_n(mem_cs_n[0])
    );

    sram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req[1]), .m0_read(m0_read[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
        .m0_rdata(m0_rdata[1]), .m0_ack(m0_ack[1]),
        .m1_req(m1_req[1]), .m1_read(m1_read[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
        .m1_rdata(m1_rdata[1]), .m1_ack(m1_ack[1]),
        .gnt(gnt[1]), .mem_addr(mem_addr[1]), .mem_dout(mem_dout[1]), .mem_din(mem_din[1]),
        .mem_rw(mem_rw[1]), .mem_cs_n(mem_cs_n[1])
    );

    // Simple asynchronous-read, write-on-edge SRAM per instance.
    logic [7:0] sram0 [65536];
    logic [7:0] sram1 [65536];
    assign mem_din[0] = sram0[mem_addr[0]];
    assign mem_din[1] = sram1[mem_addr[1]];
    always @(posedge clk) begin
        if (!mem_cs_n[0] && !mem_rw[0]) sram0[mem_addr[0]] <= mem_dout[0];
        if (!mem_cs_n[1] && !mem_rw[1]) sram1[mem_addr[1]] <= mem_dout[1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [7:0]  gold [2][65536];
    bit          last_m [2];
    logic [7:0]  exp_rd0 [2];
    logic [7:0]  exp_rd1 [2];
    logic [15:0] pool [16];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_m[d]  = 1'b1;
            exp_rd0[d] = 8'h00;
            exp_rd1[d] = 8'h00;
        end
    endtask

    task automatic check_reset(input int d);
        check_eq("rst_gnt",    32'(gnt[d]),      32'h0);
        check_eq("rst_ack0",   32'(m0_ack[d]),   32'h0);
        check_eq("rst_ack1",   32'(m1_ack[d]),   32'h0);
        check_eq("rst_rdata0", 32'(m0_rdata[d]), 32'h0);
        check_eq("rst_rdata1", 32'(m1_rdata[d]), 32'h0);
        check_eq("rst_addr",   32'(mem_addr[d]), 32'h0);
        check_eq("rst_dout",   32'(mem_dout[d]), 32'h0);
        check_eq("rst_rw",     32'(mem_rw[d]),   32'h1);
        check_eq("rst_cs_n",   32'(mem_cs_n[d]), 32'h1);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_txn(input int d, input bit r0, input bit r1,
                           input bit rd0, input bit rd1,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input bit hold, output int ack_cyc);
        int          ws;
        bit          win;
        logic [15:0] wa;
        bit          wrd;
        logic [7:0]  wd;
        int          jack;
        int          lows;
        ws = (d == 0) ? 0 : 3;
        m0_req[d] = r0; m0_read[d] = rd0; m0_addr[d] = a0; m0_wdata[d] = w0;
        m1_req[d] = r1; m1_read[d] = rd1; m1_addr[d] = a1; m1_wdata[d] = w1;
        win = r1 && (!r0 || !last_m[d]);
        last_m[d] = win;
        wa  = win ? a1 : a0;
        wrd = win ? rd1 : rd0;
        wd  = win ? w1 : w0;

        @(negedge clk);
        check_eq("grant",      32'(gnt[d]),      win ? 32'h2 : 32'h1);
        check_eq("grant_cs",   32'(mem_cs_n[d]), 32'h0);
        check_eq("grant_rw",   32'(mem_rw[d]),   32'(wrd));
        check_eq("grant_addr", 32'(mem_addr[d]), 32'(wa));
        if (!wrd) check_eq("grant_dout", 32'(mem_dout[d]), 32'(wd));
        if (!hold) begin
            m0_req[d] = 1'b0; m1_req[d] = 1'b0;
            m0_addr[d] = ~a0; m1_addr[d] = ~a1;
            m0_wdata[d] = ~w0; m1_wdata[d] = ~w1;
        end

        lows = 1;
        jack = 0;
        for (int j = 1; j <= 20 && jack == 0; j++) begin
            @(negedge clk);
            if (win ? m1_ack[d] : m0_ack[d]) begin
                jack = j;
            end else if (!mem_cs_n[d]) begin
                lows++;
                check_eq("addr_hold", 32'(mem_addr[d]), 32'(wa));
            end
        end
        check_eq("ack_latency", 32'(jack), 32'(1 + ws));
        check_eq("cs_low_len",  32'(lows), 32'(1 + ws));
        check_eq("done_other_ack", 32'(win ? m0_ack[d] : m1_ack[d]), 32'h0);
        check_eq("done_gnt",   32'(gnt[d]),      32'h0);
        check_eq("done_cs_n",  32'(mem_cs_n[d]), 32'h1);
        check_eq("done_rw",    32'(mem_rw[d]),   32'h1);

        if (wrd) begin
            if (win) exp_rd1[d] = gold[d][wa];
            else     exp_rd0[d] = gold[d][wa];
        end else begin
            gold[d][wa] = wd;
        end
        check_eq("rdata0", 32'(m0_rdata[d]), 32'(exp_rd0[d]));
        check_eq("rdata1", 32'(m1_rdata[d]), 32'(exp_rd1[d]));
        ack_cyc = cyc;

        @(negedge clk);
        check_eq("ack_pulse0", 32'(m0_ack[d]), 32'h0);
        check_eq("ack_pulse1", 32'(m1_ack[d]), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          ac;
        int          acks [4];
        int          pat;
        logic [15:0] ra0, ra1;
        m0_req = '0; m1_req = '0; m0_read = '0; m1_read = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        rst = 1'b0;
        model_reset();
        pool[0] = 16'h0012;
        pool[1] = 16'h0040;
        for (int i = 2; i < 16; i++) pool[i] = 16'($urandom);

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) check_reset(d);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("idle_gnt",  32'(gnt[d]),      32'h0);
            check_eq("idle_cs_n", 32'(mem_cs_n[d]), 32'h1);
        end

        // Write 8'hA5 to 16'h0012 and read it back through master 0 (no wait states).
        run_txn(0, 1, 0, 0, 0, 16'h0012, 16'h0, 8'hA5, 8'h00, 0, ac);
        run_txn(0, 1, 0, 1, 0, 16'h0012, 16'h0, 8'h00, 8'h00, 0, ac);
        check_eq("a5_readback", 32'(m0_rdata[0]), 32'hA5);

        // Populate every pool address on both instances via alternating single masters.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                if (i[0]) run_txn(d, 0, 1, 0, 0, 16'h0, pool[i], 8'h0, 8'($urandom), 0, ac);
                else      run_txn(d, 1, 0, 0, 0, pool[i], 16'h0, 8'($urandom), 8'h0, 0, ac);
            end
        end

        // Both masters read continuously: grants alternate, each master served every 2*(3+ws) cycles.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                run_txn(d, 1, 1, 1, 1, pool[$urandom_range(0, 15)], pool[$urandom_range(0, 15)],
                        8'h0, 8'h0, 1, acks[k]);
            end
            m0_req[d] = 1'b0;
            m1_req[d] = 1'b0;
            check_eq("tie_period_a", 32'(acks[2] - acks[0]), 32'(2 * (3 + ((d == 0) ? 0 : 3))));
            check_eq("tie_period_b", 32'(acks[3] - acks[1]), 32'(2 * (3 + ((d == 0) ? 0 : 3))));
        end

        // Three wait states: master 1 reads 16'h0040.
        run_txn(1, 0, 1, 0, 1, 16'h0, 16'h0040, 8'h0, 8'h0, 0, ac);
        check_eq("ws3_rdata", 32'(m1_rdata[1]), 32'(gold[1][16'h0040]));

        // Randomised mix of single and simultaneous requests, reads and writes.
        for (int n = 0; n < 120; n++) begin
            pat = $urandom_range(1, 3);
            ra0 = pool[$urandom_range(0, 15)];
            ra1 = pool[$urandom_range(0, 15)];
            run_txn(n % 2, pat[0], pat[1],
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                    ra0, ra1, 8'($urandom), 8'($urandom), 0, ac);
        end

        // Reset while the 3-wait-state instance is in WAIT.
        m1_req[1] = 1'b1; m1_read[1] = 1'b1; m1_addr[1] = pool[1];
        @(negedge clk);
        m1_req[1] = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_cs_n", 32'(mem_cs_n[1]), 32'h0);
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("abort_cs_n", 32'(mem_cs_n[1]), 32'h1);
        check_eq("abort_gnt",  32'(gnt[1]),      32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("abort_no_ack", 32'(m1_ack[1]), 32'h0);
        end
        check_reset(1);
        rst = 1'b1;
        @(negedge clk);
        run_txn(1, 1, 1, 1, 1, pool[1], pool[2], 8'h0, 8'h0, 0, ac);
        run_txn(0, 1, 1, 1, 1, pool[3], pool[4], 8'h0, 8'h0, 0, ac);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter that shares the single 8-bit SRAM port between the `cpu` core (master 0) and a second bus master such as a loader or DMA engine (master 1). It sits between the masters and `sram`. It serialises requests with round-robin fairness and sequences each access through a fixed setup/wait/complete cycle. Each master sees a simple req/ack handshake with registered read data.

## Interface
- `ADDR_WIDTH`, 16, address width of masters and SRAM bus
- `DATA_WIDTH`, 8, data width
- `WAIT_STATES`, 0, extra access cycles inserted per transaction (0..15)

- `clk`  in  1  single system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  transaction request; level, sampled only in IDLE
- `m0_read`, `m1_read`  in  1  1 = read, 0 = write (same sense as the cpu `read` output)
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  access address
- `m0_wdata`, `m1_wdata`  in  DATA_WIDTH  write data
- `m0_rdata`, `m1_rdata`  out  DATA_WIDTH  read data, valid while that master's ack is high and held until its next read completes
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `gnt`  out  2  one-hot current owner; 00 when idle
- `mem_addr`  out  ADDR_WIDTH  SRAM address
- `mem_dout`  out  DATA_WIDTH  write data to SRAM
- `mem_din`  in  DATA_WIDTH  read data from SRAM (combinational)
- `mem_rw`  out  1  1 = read, 0 = write
- `mem_cs_n`  out  1  SRAM chip select, active-low

## Operation
- FSM states: IDLE, SETUP, WAIT, DONE. All outputs are registered.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, pick the winner, latch its addr/read/wdata into the bus registers, set `gnt`, drive `mem_cs_n`=0, and go to SETUP.
- Arbitration:
  - A single requester always wins.
  - When both request, the master not served last wins. `last` is a 1-bit pointer updated at each grant.
  - After reset `last`=1, so master 0 wins the first tie.
- SETUP:
  - Bus is driven with `mem_rw` = latched read.
  - If `WAIT_STATES`=0, go to DONE. Otherwise load the wait counter with `WAIT_STATES`-1 and go to WAIT.
- WAIT: decrement the counter; at 0 go to DONE.
- Entry into DONE happens on the clock edge that ends the last driven cycle. On that edge:
  - For a read, capture `mem_din` into the granted master's rdata.
  - Set the granted ack to 1.
  - Set `mem_cs_n`=1, `mem_rw`=1, and `gnt`=00.
- DONE: ack high for exactly this cycle, then go to IDLE with ack back to 0.
- Request signals:
  - The masters' signals are latched at grant. Changing or dropping req/addr/data after grant has no effect, and the transaction still completes with an ack.
  - A req still high in IDLE after ack is a new transaction. Masters must drop req in the ack cycle unless they intend back-to-back access.
- Writes: `mem_rw`=0 and `mem_cs_n`=0 for SETUP+WAIT only. `mem_dout` holds the write data.
- Reads leave the non-granted master's rdata unchanged.

## Timing
- Reset values:
  - `gnt`=00, `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0
  - `mem_addr`=0, `mem_dout`=0, `mem_rw`=1, `mem_cs_n`=1
  - state IDLE, `last`=1
- Reset mid-transaction: immediate abort to reset values. No ack is issued and the pending access is lost.
- Latency: with req sampled at edge k in IDLE, ack is high in the cycle after edge k+1+`WAIT_STATES`.
- Bus occupancy per transaction: 1+`WAIT_STATES` cycles with `mem_cs_n`=0.
- Throughput: one transaction every 3+`WAIT_STATES` cycles (IDLE, SETUP, [WAIT], DONE).
- Starvation bound: a continuously requesting master waits at most one other transaction.

## Test plan
- Reset: assert `rst`=0 for 2 cycles -> all outputs at the reset values above; release -> remains IDLE with `gnt`=00.
- Single write then read, `WAIT_STATES`=0:
  - M0 writes 8'hA5 to 16'h0012 -> `mem_cs_n`=0 and `mem_rw`=0 for 1 cycle, `m0_ack` 2 edges after req.
  - M0 reads 16'h0012 -> `m0_rdata`=8'hA5 with `m0_ack`.
- Simultaneous requests held continuously: both masters read -> grants alternate M0, M1, M0, M1. Each ack arrives every 6 cycles per master; `m1_rdata` is unaffected by M0 reads.
- `WAIT_STATES`=3: M1 read of 16'h0040 -> `mem_cs_n` low exactly 4 cycles, `m1_ack` 5 edges after req, rdata matches SRAM contents.
- Request withdrawn after grant: M1 drops req and changes addr the cycle after grant -> access uses the latched address, and `m1_ack` still pulses once.
- Reset mid-WAIT: `rst`=0 during WAIT -> `mem_cs_n`=1 and `gnt`=00 immediately, no ack. After release, a tie is granted to M0.
